dcache_port_arb: RTL and testbench
==================================

# dcache_port_arb

Arbiter and sequencer for the single D-cache request port shared by the load/store unit. Each cycle it selects one command from speculative load issue and committed store drain (including store-conditional) and registers it toward the D-cache. It also holds store drain while a store-conditional is outstanding. It sits between the LSQ request side and the D-cache/MSHR, replacing direct LSQ-to-D-cache wiring.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, store data width
- STARVE_LIMIT, 8, consecutive store-lost cycles before store gets priority (1..255)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ld_req_i  in  1  load requests port
- ld_addr_i  in  ADDR_W  load address
- ld_br_mask_i  in  `BR_MASK_W  branch mask of requesting load
- st_req_i  in  1  committed store at SQ head requests port
- st_addr_i  in  ADDR_W  store address
- st_data_i  in  DATA_W  store data
- st_is_stc_i  in  1  request is store-conditional
- sq_full_i  in  1  SQ full; forces store priority
- rob_br_recovery_i  in  1  mispredict recovery this cycle
- rob_br_tag_fix_i  in  `BR_MASK_W  resolving branch tag
- Dcache_mshr_stall_i  in  1  D-cache cannot accept a command
- Dcache_stc_success_i, Dcache_stc_fail_i  in  1  stc outcome
- ld_gnt_o  out  1  load accepted this cycle (combinational)
- st_gnt_o  out  1  store accepted this cycle (combinational)
- dc_ld_en_o  out  1  registered load command valid
- dc_ld_addr_o  out  ADDR_W  registered load address
- dc_st_en_o  out  1  registered store command valid
- dc_st_addr_o, dc_st_data_o  out  ADDR_W/DATA_W  registered store command
- dc_stc_flag_o  out  1  registered store is stc
- stc_done_o  out  1  one-cycle pulse when stc resolves
- stc_success_o  out  1  outcome qualifying stc_done_o
- stc_busy_o  out  1  state is STC_WAIT

## Operation
- Grant: at most one of ld_gnt_o/st_gnt_o per cycle. No grant while Dcache_mshr_stall_i=1.
- Load eligible: ld_req_i=1, and not squashed. Squashed means rob_br_recovery_i=1 and (ld_br_mask_i & rob_br_tag_fix_i)!=0.
- Store eligible: st_req_i=1, state IDLE.
- Priority: loads win by default. Stores win when sq_full_i=1 or starve_cnt>=STARVE_LIMIT.
- starve_cnt: saturating counter, width $clog2(STARVE_LIMIT+1).
  - Increments when a store is eligible but not granted.
  - Clears on st_gnt_o.
  - Holds when no store is eligible.
- FSM IDLE -> STC_WAIT on st_gnt_o with st_is_stc_i=1.
- STC_WAIT -> IDLE on success or fail. In that cycle, stc_done_o=1 and stc_success_o=Dcache_stc_success_i.
- Loads are still granted in STC_WAIT.
- Success and fail both high is illegal; success takes precedence.
- An outcome arriving in IDLE is ignored.

## Timing
- Grants are combinational in the request cycle; the requester dequeues on grant.
- Command registers load on the clock edge after the grant. Exactly one of dc_ld_en_o/dc_st_en_o is high for exactly one cycle per grant.
- Without a grant, the en outputs are 0. Address/data hold their last values.
- stc_done_o/stc_success_o are registered: they pulse the cycle after the outcome input.
- Earliest STC_WAIT exit: outcome two cycles after st_gnt_o (command issues one cycle after grant).
- Reset values:
  - All outputs 0.
  - State IDLE, starve_cnt 0.
  - Reset during STC_WAIT abandons the stc; no done pulse.
- Recovery with a non-matching mask does not block a load grant.

## Configuration
- DCACHE_ARB_STARVE_EN defined: starvation counter and STARVE_LIMIT priority inversion as above.
- Undefined: counter removed; stores win only on sq_full_i=1; STARVE_LIMIT unused.

## Structure
- Shared package: arb state enum (IDLE, STC_WAIT) and a D-cache command struct (en, addr, data, stc flag). `BR_MASK_W comes from the existing defines.
- One sub-module: dcache_arb_starve_ctr (saturating counter with clear), instantiated only under DCACHE_ARB_STARVE_EN.

## Test plan
- Load only, addr 0x100 -> ld_gnt_o same cycle; next cycle dc_ld_en_o=1, dc_ld_addr_o=0x100, dc_st_en_o=0.
- Load and store both held 8 cycles, STARVE_LIMIT=8 -> loads granted cycles 0-7; store granted cycle 8; starve_cnt back to 0.
- sq_full_i=1 with both requesting -> st_gnt_o=1, ld_gnt_o=0.
- Stc granted, Dcache_stc_fail_i 3 cycles later -> further stores blocked while loads are granted; stc_done_o=1, stc_success_o=0 next cycle; IDLE after.
- Load mask 0b0010, recovery with tag_fix 0b0010 -> no grant, dc_ld_en_o=0. Tag_fix 0b0100 -> granted.
- Dcache_mshr_stall_i=1 for 2 cycles with requests pending -> no grants, no commands; grant resumes the cycle stall drops.

Source files
------------

// File: rtl/dcache_port_arb_pkg.sv
// dcache_port_arb_pkg: shared arbiter state and D-cache command types.
`ifndef BR_MASK_W
`define BR_MASK_W 8
`endif
package dcache_port_arb_pkg;
    localparam int DC_ADDR_W = 64;
    localparam int DC_DATA_W = 64;
    typedef enum logic {IDLE, STC_WAIT} arb_state_e;
    typedef struct packed {
        logic                 en;
        logic [DC_ADDR_W-1:0] addr;
        logic [DC_DATA_W-1:0] data;
        logic                 stc;
    } dcache_cmd_t;
endpackage

// File: rtl/dcache_arb_starve_ctr.sv
// dcache_arb_starve_ctr: saturating up-counter with synchronous clear.
module dcache_arb_starve_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dcache_port_arb.sv
// dcache_port_arb: load/store arbiter and stc sequencer for the D-cache request port.
// DCACHE_ARB_STARVE_EN enables the store starvation counter.
module dcache_port_arb
    import dcache_port_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req_i,
    input  logic [ADDR_W-1:0]     ld_addr_i,
    input  logic [`BR_MASK_W-1:0] ld_br_mask_i,
    input  logic                  st_req_i,
    input  logic [ADDR_W-1:0]     st_addr_i,
    input  logic [DATA_W-1:0]     st_data_i,
    input  logic                  st_is_stc_i,
    input  logic                  sq_full_i,
    input  logic                  rob_br_recovery_i,
    input  logic [`BR_MASK_W-1:0] rob_br_tag_fix_i,
    input  logic                  Dcache_mshr_stall_i,
    input  logic                  Dcache_stc_success_i,
    input  logic                  Dcache_stc_fail_i,
    output logic                  ld_gnt_o,
    output logic                  st_gnt_o,
    output logic                  dc_ld_en_o,
    output logic [ADDR_W-1:0]     dc_ld_addr_o,
    output logic                  dc_st_en_o,
    output logic [ADDR_W-1:0]     dc_st_addr_o,
    output logic [DATA_W-1:0]     dc_st_data_o,
    output logic                  dc_stc_flag_o,
    output logic                  stc_done_o,
    output logic                  stc_success_o,
    output logic                  stc_busy_o
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..255");
    end

    arb_state_e        state, state_n;
    dcache_cmd_t       st_cmd;
    logic              ld_elig, st_elig, st_pri, stc_res;
    logic [ADDR_W-1:0] ld_addr_q;
    logic              ld_en_q;

    assign ld_elig = ld_req_i && !(rob_br_recovery_i && |(ld_br_mask_i & rob_br_tag_fix_i));
    assign st_elig = st_req_i && state == IDLE;

`ifdef DCACHE_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt;

    dcache_arb_starve_ctr #(.W(CW)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (st_elig && !st_gnt_o),
        .clr (st_gnt_o),
        .cnt (starve_cnt)
    );

    assign st_pri = sq_full_i || starve_cnt >= CW'(STARVE_LIMIT);
`else
    assign st_pri = sq_full_i;
`endif

    // A store also wins whenever no load is eligible.
    assign st_gnt_o = !Dcache_mshr_stall_i && st_elig && (st_pri || !ld_elig);
    assign ld_gnt_o = !Dcache_mshr_stall_i && ld_elig && !st_gnt_o;
    assign stc_res  = state == STC_WAIT && (Dcache_stc_success_i || Dcache_stc_fail_i);

    always_comb begin
        state_n = (state == IDLE) ? ((st_gnt_o && st_is_stc_i) ? STC_WAIT : IDLE)
                                  : (stc_res ? IDLE : STC_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            st_cmd        <= '0;
            ld_en_q       <= 1'b0;
            ld_addr_q     <= '0;
            stc_done_o    <= 1'b0;
            stc_success_o <= 1'b0;
        end else begin
            state         <= state_n;
            ld_en_q       <= ld_gnt_o;
            st_cmd.en     <= st_gnt_o;
            stc_done_o    <= stc_res;
            stc_success_o <= stc_res && Dcache_stc_success_i;
            if (ld_gnt_o) ld_addr_q <= ld_addr_i;
            if (st_gnt_o) begin
                st_cmd.addr <= DC_ADDR_W'(st_addr_i);
                st_cmd.data <= DC_DATA_W'(st_data_i);
                st_cmd.stc  <= st_is_stc_i;
            end
        end
    end

    assign dc_ld_en_o    = ld_en_q;
    assign dc_ld_addr_o  = ld_addr_q;
    assign dc_st_en_o    = st_cmd.en;
    assign dc_st_addr_o  = ADDR_W'(st_cmd.addr);
    assign dc_st_data_o  = DATA_W'(st_cmd.data);
    assign dc_stc_flag_o = st_cmd.stc;
    assign stc_busy_o    = state == STC_WAIT;
endmodule

// File: tb/tb_dcache_port_arb.sv
// tb_dcache_port_arb: directed stimulus checked against a cycle model and literal expectations.
`ifndef BR_MASK_W
`define BR_MASK_W 8
`endif
module tb_dcache_port_arb;
    localparam int LIMIT = 8;
    localparam int SW    = $clog2(LIMIT + 1);
    localparam int SAT   = (1 << SW) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic ld_req, st_req, st_is_stc, sq_full, rec, stall, succ, fail;
    logic [63:0] ld_addr, st_addr, st_data;
    logic [`BR_MASK_W-1:0] mask, tag;
    logic ld_gnt, st_gnt, dc_ld_en, dc_st_en, dc_stc_flag, stc_done, stc_success, stc_busy;
    logic [63:0] dc_ld_addr, dc_st_addr, dc_st_data;

    int n_cmp = 0, n_bad = 0;

    dcache_port_arb #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_br_mask_i(mask),
        .st_req_i(st_req), .st_addr_i(st_addr), .st_data_i(st_data), .st_is_stc_i(st_is_stc),
        .sq_full_i(sq_full), .rob_br_recovery_i(rec), .rob_br_tag_fix_i(tag),
        .Dcache_mshr_stall_i(stall), .Dcache_stc_success_i(succ), .Dcache_stc_fail_i(fail),
        .ld_gnt_o(ld_gnt), .st_gnt_o(st_gnt),
        .dc_ld_en_o(dc_ld_en), .dc_ld_addr_o(dc_ld_addr),
        .dc_st_en_o(dc_st_en), .dc_st_addr_o(dc_st_addr), .dc_st_data_o(dc_st_data),
        .dc_stc_flag_o(dc_stc_flag), .stc_done_o(stc_done), .stc_success_o(stc_success),
        .stc_busy_o(stc_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the port must present after the next clock edge.
    bit          mv = 0, m_busy, m_ld_en, m_st_en, m_stc, m_done, m_succ;
    logic [63:0] m_ld_addr, m_st_addr, m_st_data;
    int          m_starve;

    always @(negedge clk) begin
        bit le, se, pri, sg, lg;
        if (mv) begin
            chk("dc_ld_en", dc_ld_en, m_ld_en);
            chk("dc_ld_addr", dc_ld_addr, m_ld_addr);
            chk("dc_st_en", dc_st_en, m_st_en);
            chk("dc_st_addr", dc_st_addr, m_st_addr);
            chk("dc_st_data", dc_st_data, m_st_data);
            if (m_st_en) chk("dc_stc_flag", dc_stc_flag, m_stc);
            chk("stc_done", stc_done, m_done);
            chk("stc_success", stc_success, m_succ);
            chk("stc_busy", stc_busy, m_busy);
        end
        if (rst) begin
            mv = 1; m_busy = 0; m_ld_en = 0; m_st_en = 0; m_stc = 0; m_done = 0; m_succ = 0;
            m_ld_addr = 0; m_st_addr = 0; m_st_data = 0; m_starve = 0;
        end else if (mv) begin
            le  = ld_req && !(rec && (mask & tag) != 0);
            se  = st_req && !m_busy;
`ifdef DCACHE_ARB_STARVE_EN
            pri = sq_full || m_starve >= LIMIT;
`else
            pri = sq_full;
`endif
            sg  = !stall && se && (pri || !le);
            lg  = !stall && le && !sg;
            chk("ld_gnt", ld_gnt, lg);
            chk("st_gnt", st_gnt, sg);
            m_ld_en = lg;
            m_st_en = sg;
            if (lg) m_ld_addr = ld_addr;
            if (sg) begin m_st_addr = st_addr; m_st_data = st_data; m_stc = st_is_stc; end
            m_done = m_busy && (succ || fail);
            m_succ = m_done && succ;
            if (m_busy) m_busy = !(succ || fail);
            else m_busy = sg && st_is_stc;
            if (sg) m_starve = 0;
            else if (se && m_starve < SAT) m_starve++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_st;
        {ld_req, st_req, st_is_stc, sq_full, rec, stall, succ, fail} = '0;
        ld_addr = 0; st_addr = 0; st_data = 0; mask = 0; tag = 0;
        repeat (3) tick;
        chk("rst_ld_en", dc_ld_en, 0);
        chk("rst_st_en", dc_st_en, 0);
        chk("rst_done", stc_done, 0);
        chk("rst_busy", stc_busy, 0);
        rst = 0;
        tick;
        // single load
        ld_req = 1; ld_addr = 64'h100; #1;
        chk("t1_ld_gnt", ld_gnt, 1);
        chk("t1_st_gnt", st_gnt, 0);
        tick;
        ld_req = 0;
        chk("t1_dc_ld_en", dc_ld_en, 1);
        chk("t1_dc_ld_addr", dc_ld_addr, 64'h100);
        chk("t1_dc_st_en", dc_st_en, 0);
        tick;
        chk("t1_ld_en_pulse", dc_ld_en, 0);
        // store starvation behind loads
        ld_req = 1; st_req = 1; st_addr = 64'h200; st_data = 64'hAB;
        for (int c = 0; c <= 8; c++) begin
            ld_addr = 64'h1000 + 64'(c); #1;
`ifdef DCACHE_ARB_STARVE_EN
            exp_st = (c == 8);
`else
            exp_st = 0;
`endif
            chk("starve_st_gnt", st_gnt, exp_st);
            chk("starve_ld_gnt", ld_gnt, !exp_st);
            tick;
        end
`ifdef DCACHE_ARB_STARVE_EN
        chk("starve_dc_st_en", dc_st_en, 1);
        chk("starve_dc_st_addr", dc_st_addr, 64'h200);
        #1;
        chk("starve_cleared_ld_wins", ld_gnt, 1);
`endif
        // sq_full forces store priority
        sq_full = 1; #1;
        chk("full_st_gnt", st_gnt, 1);
        chk("full_ld_gnt", ld_gnt, 0);
        tick;
        {ld_req, st_req, sq_full} = '0;
        chk("full_dc_st_en", dc_st_en, 1);
        chk("full_dc_st_data", dc_st_data, 64'hAB);
        // stc, fail three cycles after grant
        st_req = 1; st_is_stc = 1; st_addr = 64'h300; #1;
        chk("stc_gnt", st_gnt, 1);
        tick;
        st_is_stc = 0; st_addr = 64'h308; ld_req = 1; #1;
        chk("stc_busy1", stc_busy, 1);
        chk("stc_block_st", st_gnt, 0);
        chk("stc_ld_ok", ld_gnt, 1);
        tick;
        #1 chk("stc_block_st2", st_gnt, 0);
        tick;
        fail = 1; #1;
        chk("stc_block_st3", st_gnt, 0);
        tick;
        {fail, st_req, ld_req} = '0;
        chk("stc_fail_done", stc_done, 1);
        chk("stc_fail_succ", stc_success, 0);
        chk("stc_fail_idle", stc_busy, 0);
        tick;
        chk("stc_done_pulse", stc_done, 0);
        // stc, success at the earliest point
        st_req = 1; st_is_stc = 1; st_addr = 64'h400;
        tick;
        st_req = 0; st_is_stc = 0;
        tick;
        succ = 1;
        tick;
        succ = 0;
        chk("stc_ok_done", stc_done, 1);
        chk("stc_ok_succ", stc_success, 1);
        // outcome while idle is ignored
        succ = 1;
        tick;
        succ = 0;
        chk("idle_outcome", stc_done, 0);
        // branch squash
        ld_req = 1; mask = 'b0010; rec = 1; tag = 'b0010; ld_addr = 64'h500; #1;
        chk("squash_gnt", ld_gnt, 0);
        tick;
        chk("squash_dc_ld_en", dc_ld_en, 0);
        tag = 'b0100; #1;
        chk("nosquash_gnt", ld_gnt, 1);
        tick;
        {rec, ld_req} = '0;
        chk("nosquash_dc_ld_en", dc_ld_en, 1);
        // mshr stall
        ld_req = 1; st_req = 1; stall = 1; ld_addr = 64'h600; st_addr = 64'h608; #1;
        chk("stall_ld_gnt", ld_gnt, 0);
        chk("stall_st_gnt", st_gnt, 0);
        tick;
        chk("stall_ld_en", dc_ld_en, 0);
        tick;
        stall = 0;
        chk("stall_st_en", dc_st_en, 0);
        #1 chk("unstall_ld_gnt", ld_gnt, 1);
        tick;
        {ld_req, st_req} = '0;
        chk("unstall_dc_ld_addr", dc_ld_addr, 64'h600);
        // reset while an stc is outstanding
        st_req = 1; st_is_stc = 1;
        tick;
        {st_req, st_is_stc} = '0;
        tick;
        rst = 1; succ = 1;
        tick;
        rst = 0; succ = 0;
        chk("rst_stc_done", stc_done, 0);
        chk("rst_stc_busy", stc_busy, 0);
        tick;
        chk("rst_stc_done2", stc_done, 0);
        // mixed sweep, model-checked every cycle
        for (int i = 0; i < 60; i++) begin
            ld_req    = (i % 3) != 1;
            st_req    = (i % 4) != 2;
            st_is_stc = (i % 5) == 0;
            sq_full   = (i % 7) == 3;
            stall     = (i % 9) == 4;
            rec       = (i % 8) == 5;
            mask      = 'b0010;
            tag       = `BR_MASK_W'(1 << (i % 3));
            succ      = (i % 7) == 2;
            fail      = (i % 6) == 1 && !succ;
            ld_addr   = 64'h7000 + 64'(i);
            st_addr   = 64'h8000 + 64'(i);
            st_data   = 64'hD000 + 64'(i);
            tick;
        end
        {ld_req, st_req, st_is_stc, sq_full, rec, stall, succ, fail} = '0;
        repeat (2) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
